// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the MIPS run-control block: debug command opcodes,
// sequencer states and the default reset-stretch length.
package cpu_dbg_pkg;

    localparam int RST_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_RUN     = 3'd1,
        OP_HALT    = 3'd2,
        OP_STEP    = 3'd3,
        OP_LOAD_PC = 3'd4,
        OP_SET_BP  = 3'd5,
        OP_CLR_BP  = 3'd6
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RSEQ = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/debug command channel into the run controller; the host drives the
// command fields and the controller answers with cmd_ready.
interface cpu_run_ctrl_if
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W = 32
);
    logic            cmd_valid;
    cmd_op_e         cmd_op;
    logic [PC_W-1:0] cmd_data;
    logic [2:0]      cmd_idx;
    logic            cmd_ready;

    modport master (output cmd_valid, cmd_op, cmd_data, cmd_idx, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_idx, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_bp_match.sv
// PC breakpoint channels: per-channel address and enable registers, with a
// combinational match vector against the core's current PC.
module cpu_bp_match
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [2:0]        idx_i,
    input  logic [PC_W-1:0]   addr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [NUM_BP-1:0] match_o
);

    logic [PC_W-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;

    // Channel indices beyond NUM_BP never compare equal, so they are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bp_en_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (idx_i == 3'(i)) begin
                    if (set_i) begin
                        bp_addr_q[i] <= addr_i;
                        bp_en_q[i]   <= 1'b1;
                    end else if (clr_i) begin
                        bp_en_q[i]   <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        match_o = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match_o[i] = bp_en_q[i] && (bp_addr_q[i] == pc_i);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control and reset sequencer for the multicycle MIPS core: RUN/HALT/STEP,
// PC breakpoints, initial-PC injection. CPU_RUN_CTRL_CYCLE_CNT_EN adds counters.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int NUM_BP     = 2,
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int AUTO_RUN   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    cpu_run_ctrl_if.slave     cmd,
    input  logic [PC_W-1:0]   now_pc,
    input  logic              ins_fetch,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic [PC_W-1:0]   outside_pc,
    output logic              halted,
    output logic [NUM_BP-1:0] bp_hit
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);

    run_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [NUM_BP-1:0] hit_q, hit_d;
    logic [NUM_BP-1:0] bp_match;
    logic              skip_q, skip_d;
    logic              en_ok_q;
    logic              accept;

    assign cmd.cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    cpu_bp_match #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP)
    ) u_bp (
        .CLK     (CLK),
        .RST     (RST),
        .set_i   (accept && (cmd.cmd_op == OP_SET_BP)),
        .clr_i   (accept && (cmd.cmd_op == OP_CLR_BP)),
        .idx_i   (cmd.cmd_idx),
        .addr_i  (cmd.cmd_data),
        .pc_i    (now_pc),
        .match_o (bp_match)
    );

    // en_ok_q keeps cpu_en low in the very first cycle after RST, matching the reset value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RSEQ;
            cnt_q   <= CNT_INIT;
            pc_q    <= '0;
            hit_q   <= '0;
            skip_q  <= 1'b0;
            en_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            hit_q   <= hit_d;
            skip_q  <= skip_d;
            en_ok_q <= 1'b1;
        end
    end

    // skip_q masks the first fetch after a RUN restart so a halted-on breakpoint is stepped past.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        hit_d   = hit_q;
        skip_d  = skip_q;
        unique case (state_q)
            ST_RSEQ: begin
                if (cnt_q == '0) begin
                    state_d = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_RUN: begin
                            state_d = ST_RUN;
                            hit_d   = '0;
                            skip_d  = 1'b1;
                        end
                        OP_STEP:    state_d = ST_STEP;
                        OP_LOAD_PC: begin
                            pc_d    = cmd.cmd_data;
                            cnt_d   = CNT_INIT;
                            skip_d  = 1'b0;
                            state_d = ST_RSEQ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (ins_fetch) begin
                    skip_d = 1'b0;
                    if (!skip_q && (bp_match != '0)) begin
                        hit_d   = hit_q | bp_match;
                        state_d = ST_HALT;
                    end
                end
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_HALT:    state_d = ST_HALT;
                        OP_LOAD_PC: begin
                            pc_d    = cmd.cmd_data;
                            cnt_d   = CNT_INIT;
                            skip_d  = 1'b0;
                            state_d = ST_RSEQ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                if (ins_fetch) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_RSEQ;
        endcase
    end

    assign cpu_rst    = (state_q == ST_RSEQ);
    assign cpu_en     = en_ok_q && (state_q != ST_HALT);
    assign halted     = (state_q == ST_HALT);
    assign outside_pc = pc_q;
    assign bp_hit     = hit_q;

`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q, ret_q;

    always_ff @(posedge CLK) begin
        if (RST || (state_q == ST_RSEQ)) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (cpu_en && !cpu_rst) cyc_q <= cyc_q + 32'd1;
            if (ins_fetch && cpu_en) ret_q <= ret_q + 32'd1;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed vectors push expected status
// snapshots, a negedge monitor pops and compares them.
module tb_cpu_run_ctrl;
    import cpu_dbg_pkg::*;

    typedef struct {
        int          cyc;
        string       name;
        logic [37:0] vec;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] nowPc;
    logic        insFetch;
    logic        cpuRst, cpuEn, halted;
    logic [31:0] outsidePc;
    logic [1:0]  bpHit;
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycCnt, retCnt;
`endif

    exp_t sbQ[$];
    exp_t monExp;
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycCount   = 0;

    cpu_run_ctrl_if #(.PC_W(32)) cmdIf ();

    cpu_run_ctrl #(
        .PC_W       (32),
        .NUM_BP     (2),
        .RST_CYCLES (2),
        .AUTO_RUN   (0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd        (cmdIf),
        .now_pc     (nowPc),
        .ins_fetch  (insFetch),
        .cpu_rst    (cpuRst),
        .cpu_en     (cpuEn),
        .outside_pc (outsidePc),
        .halted     (halted),
        .bp_hit     (bpHit)
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
        ,
        .cyc_cnt    (cycCnt),
        .ret_cnt    (retCnt)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycCount <= cycCount + 1;

    function automatic logic [37:0] pack(input logic r, input logic e, input logic h,
                                         input logic rd, input logic [31:0] pc,
                                         input logic [1:0] hit);
        return {r, e, h, rd, pc, hit};
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [37:0] act;
        act = {cpuRst, cpuEn, halted, cmdIf.cmd_ready, outsidePc, bpHit};
        checkCount++;
        if (act === e.vec) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got rst=%b en=%b halt=%b rdy=%b pc=%h hit=%b, expected rst=%b en=%b halt=%b rdy=%b pc=%h hit=%b",
                     e.name, act[37], act[36], act[35], act[34], act[33:2], act[1:0],
                     e.vec[37], e.vec[36], e.vec[35], e.vec[34], e.vec[33:2], e.vec[1:0]);
        end
    endtask

    // One vector = one clock of inputs, followed by the status expected after that edge.
    task automatic applyStimulus(input string name, input logic rstIn, input logic v,
                                 input cmd_op_e op, input logic [31:0] data,
                                 input logic [2:0] idx, input logic f,
                                 input logic [31:0] pc, input logic [37:0] expVec);
        exp_t e;
        RST             = rstIn;
        cmdIf.cmd_valid = v;
        cmdIf.cmd_op    = op;
        cmdIf.cmd_data  = data;
        cmdIf.cmd_idx   = idx;
        insFetch        = f;
        nowPc           = pc;
        @(posedge CLK);
        #1;
        e.cyc  = cycCount;
        e.name = name;
        e.vec  = expVec;
        sbQ.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (sbQ.size() > 0 && sbQ[0].cyc == cycCount) begin
            monExp = sbQ.pop_front();
            checkOutput(monExp);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [37:0] runPc40;
        runPc40 = pack(0, 1, 0, 1, 32'h40, 2'b00);

        applyStimulus("rst_a",        1, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 0, 0, 0, 32'h0, 2'b00));
        applyStimulus("rst_b",        1, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 0, 0, 0, 32'h0, 2'b00));
        applyStimulus("rst_c",        1, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 0, 0, 0, 32'h0, 2'b00));
        applyStimulus("rseq_1",       0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h0, 2'b00));
        applyStimulus("rseq_halt",    0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(0, 0, 1, 1, 32'h0, 2'b00));

        applyStimulus("loadpc",       0, 1, OP_LOAD_PC, 32'h40, 3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h40, 2'b00));
        applyStimulus("loadpc_rseq2", 0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h40, 2'b00));
        applyStimulus("loadpc_halt",  0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(0, 0, 1, 1, 32'h40, 2'b00));
        applyStimulus("run",          0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  runPc40);

        applyStimulus("setbp0",       0, 1, OP_SET_BP,  32'h48, 3'd0, 0, 32'h0,  runPc40);
        applyStimulus("fetch44",      0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h44, runPc40);
        applyStimulus("fetch48_hit",  0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h48, pack(0, 0, 1, 1, 32'h40, 2'b01));
        applyStimulus("rerun",        0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("refetch48",    0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h48, runPc40);
        applyStimulus("fetch4c",      0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h4c, runPc40);
        applyStimulus("fetch48_again",0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h48, pack(0, 0, 1, 1, 32'h40, 2'b01));

        applyStimulus("step",         0, 1, OP_STEP,    32'h0,  3'd0, 0, 32'h0,  pack(0, 1, 0, 0, 32'h40, 2'b01));
        applyStimulus("step_wait",    0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(0, 1, 0, 0, 32'h40, 2'b01));
        applyStimulus("step_fetch",   0, 1, OP_LOAD_PC, 32'h99, 3'd0, 1, 32'h48, pack(0, 0, 1, 1, 32'h40, 2'b01));
        applyStimulus("run2",         0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("step_in_run",  0, 1, OP_STEP,    32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("run_hold",     0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  runPc40);

        applyStimulus("fetch10",      0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h10, runPc40);
        applyStimulus("setbp1",       0, 1, OP_SET_BP,  32'h48, 3'd1, 0, 32'h0,  runPc40);
        applyStimulus("setbp7",       0, 1, OP_SET_BP,  32'h10, 3'd7, 0, 32'h0,  runPc40);
        applyStimulus("halt_and_bp",  0, 1, OP_HALT,    32'h0,  3'd0, 1, 32'h48, pack(0, 0, 1, 1, 32'h40, 2'b11));
        applyStimulus("run3",         0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("fetch20",      0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h20, runPc40);
        applyStimulus("fetch10_nobp", 0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h10, runPc40);
        applyStimulus("clrbp0",       0, 1, OP_CLR_BP,  32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("fetch48_ch1",  0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h48, pack(0, 0, 1, 1, 32'h40, 2'b10));

        applyStimulus("run4",         0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  runPc40);
        applyStimulus("rst_mid",      1, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 0, 0, 0, 32'h0, 2'b00));
        applyStimulus("rst_rseq",     0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h0, 2'b00));
        applyStimulus("rst_halt",     0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(0, 0, 1, 1, 32'h0, 2'b00));
        applyStimulus("run5",         0, 1, OP_RUN,     32'h0,  3'd0, 0, 32'h0,  pack(0, 1, 0, 1, 32'h0, 2'b00));
        applyStimulus("fetch44b",     0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h44, pack(0, 1, 0, 1, 32'h0, 2'b00));
        applyStimulus("bp_cleared",   0, 0, OP_NOP,     32'h0,  3'd0, 1, 32'h48, pack(0, 1, 0, 1, 32'h0, 2'b00));
        applyStimulus("loadpc_run",   0, 1, OP_LOAD_PC, 32'h80, 3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h80, 2'b00));
        applyStimulus("loadpc_rseq3", 0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(1, 1, 0, 0, 32'h80, 2'b00));
        applyStimulus("loadpc_halt3", 0, 0, OP_NOP,     32'h0,  3'd0, 0, 32'h0,  pack(0, 0, 1, 1, 32'h80, 2'b00));

        @(negedge CLK);
        #1;
        if (sbQ.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sbQ.size());
            checkCount += sbQ.size();
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
